// File: rtl/vu_peak_meter.sv
// VU meter display stage: maps a 12-bit magnitude onto an 8-segment bar with
// instant attack and timed decay, a hold-then-fall peak dot and a held overload flag.
module vu_peak_meter #(
    parameter int DATA_W    = 12,
    parameter int HOLD_CNT  = 22000,
    parameter int DECAY_CNT = 2750
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sample_en,
    input  logic [DATA_W-1:0] din,
    output logic [7:0]        leds,
    output logic [3:0]        peak_level,
    output logic              overload
);

    localparam int HOLD_W  = (HOLD_CNT > 1) ? $clog2(HOLD_CNT) : 1;
    localparam int DECAY_W = (DECAY_CNT > 1) ? $clog2(DECAY_CNT) : 1;
    localparam logic [HOLD_W-1:0]  HOLD_LOAD  = HOLD_W'(HOLD_CNT - 1);
    localparam logic [DECAY_W-1:0] DECAY_LAST = DECAY_W'(DECAY_CNT - 1);

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        FALL
    } peak_state_t;

    peak_state_t        state, state_next;
    logic [3:0]         peak, peak_next;
    logic [3:0]         bar, bar_next;
    logic [HOLD_W-1:0]  hold_cnt, hold_next;
    logic [HOLD_W-1:0]  ovl_cnt, ovl_cnt_next;
    logic               ovl_next;
    logic [DECAY_W-1:0] presc, presc_next;
    logic [3:0]         level;
    logic               decay_tick;
    logic [7:0]         leds_next;

    always_comb begin
        level = '0;
        if (din != '0) begin
            level = {1'b0, din[DATA_W-1 -: 3]} + 4'd1;
        end
    end

    assign decay_tick = sample_en && (presc == DECAY_LAST);

    always_comb begin
        presc_next = presc;
        if (sample_en) begin
            presc_next = decay_tick ? '0 : presc + DECAY_W'(1);
        end
    end

    always_comb begin
        bar_next = bar;
        if (sample_en) begin
            if (level >= bar) begin
                bar_next = level;
            end else if (decay_tick && bar != '0) begin
                bar_next = bar - 4'd1;
            end
        end
    end

    // A new peak at or above the current one preempts every state transition.
    always_comb begin
        state_next = state;
        peak_next  = peak;
        hold_next  = hold_cnt;
        if (sample_en) begin
            if (level >= peak && level != '0) begin
                peak_next  = level;
                hold_next  = HOLD_LOAD;
                state_next = HOLD;
            end else begin
                case (state)
                    HOLD: begin
                        if (hold_cnt != '0) begin
                            hold_next = hold_cnt - HOLD_W'(1);
                        end else begin
                            state_next = FALL;
                        end
                    end
                    FALL: begin
                        if (decay_tick && peak != '0) begin
                            peak_next = peak - 4'd1;
                            if (peak == 4'd1) begin
                                state_next = IDLE;
                            end
                        end
                    end
                    IDLE: begin
                        peak_next = '0;
                    end
                    default: begin
                        state_next = IDLE;
                        peak_next  = '0;
                    end
                endcase
            end
            // The dot never sits below the bar; a clamped dot keeps falling.
            if (bar_next > peak_next) begin
                peak_next = bar_next;
                if (state_next == IDLE) begin
                    state_next = FALL;
                end
            end
        end
    end

    always_comb begin
        leds_next = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            leds_next[i] = (4'(i) < bar_next) ||
                           (peak_next != '0 && 4'(i) == peak_next - 4'd1);
        end
    end

    always_comb begin
        ovl_next     = overload;
        ovl_cnt_next = ovl_cnt;
        if (sample_en) begin
            if (din == '1) begin
                ovl_next     = 1'b1;
                ovl_cnt_next = HOLD_LOAD;
            end else if (ovl_cnt != '0) begin
                ovl_cnt_next = ovl_cnt - HOLD_W'(1);
            end else begin
                ovl_next = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            peak     <= '0;
            bar      <= '0;
            hold_cnt <= '0;
            ovl_cnt  <= '0;
            overload <= 1'b0;
            presc    <= '0;
            leds     <= '0;
        end else begin
            state    <= state_next;
            peak     <= peak_next;
            bar      <= bar_next;
            hold_cnt <= hold_next;
            ovl_cnt  <= ovl_cnt_next;
            overload <= ovl_next;
            presc    <= presc_next;
            if (sample_en) begin
                leds <= leds_next;
            end
        end
    end

    assign peak_level = peak;

endmodule
